// File: rtl/soc_matrix_sysid_ext.sv
// soc_matrix_sysid_ext: system ID, timestamp, caps, freezable uptime counter with coherent snapshot, scratch regs
module soc_matrix_sysid_ext #(
  parameter logic [31:0] ID_VALUE      = 32'hA5A5_0001,
  parameter logic [31:0] TIMESTAMP     = 32'd0,
  parameter int          CNT_W         = 64,
  parameter int          NUM_SCRATCH   = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  localparam int SN = NUM_SCRATCH > 0 ? NUM_SCRATCH : 1;
  logic [CNT_W-1:0] cnt, cnt_wr;
  logic [31:0]      shadow_hi, mask, rd_val;
  logic [63:0]      cnt_ext;
  logic             freeze, wr_lo, wr_hi, wr_ctrl, clr;
  logic [31:0]      scratch [SN];
  assign mask    = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign cnt_ext = 64'(cnt);
  assign wr_lo   = write && address == 4'd3;
  assign wr_hi   = write && address == 4'd4;
  assign wr_ctrl = write && address == 4'd5 && byteenable[0];
  assign clr     = wr_ctrl && writedata[0];
  assign cnt_wr  = wr_lo ? CNT_W'({cnt_ext[63:32], (cnt_ext[31:0] & ~mask) | (writedata & mask)})
                         : CNT_W'({(cnt_ext[63:32] & ~mask) | (writedata & mask), cnt_ext[31:0]});
  always_comb begin
    rd_val = '0;
    case (address)
      4'd0:    rd_val = ID_VALUE;
      4'd1:    rd_val = TIMESTAMP;
      4'd2:    rd_val = {16'h0, 4'h0, 4'(NUM_SCRATCH), 8'(CNT_W)};
      4'd3:    rd_val = cnt_ext[31:0];
      4'd4:    rd_val = shadow_hi;
      4'd5:    rd_val = {30'b0, freeze, 1'b0};
      default: for (int i = 0; i < NUM_SCRATCH; i++) if (address == 4'(6 + i)) rd_val = scratch[i];
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      cnt           <= '0;
      shadow_hi     <= '0;
      freeze        <= 1'b0;
      for (int i = 0; i < SN; i++) scratch[i] <= SCRATCH_RESET;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_val;
      // LO read snapshots the upper half so a following HI read is coherent
      if (read && address == 4'd3) shadow_hi <= cnt_ext[63:32];
      if (clr) begin
        cnt       <= '0;
        shadow_hi <= '0;
      end else if (wr_lo || wr_hi) cnt <= cnt_wr;
      else if (!freeze) cnt <= cnt + CNT_W'(1);
      if (wr_ctrl) freeze <= writedata[1];
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (write && address == 4'(6 + i)) scratch[i] <= (scratch[i] & ~mask) | (writedata & mask);
    end
  end
endmodule
